// File: rtl/marchc_pkg.sv
// March C engine shared definitions: element encodings, FSM states, slot
// lengths, slot phases and per-element lookup helpers.
package marchc_pkg;

  typedef enum logic [2:0] {
    ELEM_W0      = 3'd0,  // up,   w0
    ELEM_R0W1_UP = 3'd1,  // up,   r0 w1
    ELEM_R1W0_UP = 3'd2,  // up,   r1 w0
    ELEM_R0W1_DN = 3'd3,  // down, r0 w1
    ELEM_R1W0_DN = 3'd4,  // down, r1 w0
    ELEM_R0      = 3'd5   // up,   r0
  } elem_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [3:0] SLOT_W   = 4'd5;
  localparam logic [3:0] SLOT_RW  = 4'd9;
  localparam logic [3:0] SLOT_R   = 4'd4;

  localparam logic [3:0] PH_RD    = 4'd1;
  localparam logic [3:0] PH_WR_RW = 4'd5;
  localparam logic [3:0] PH_WR_W  = 4'd1;

  function automatic logic elem_is_down(input elem_e e);
    return (e == ELEM_R0W1_DN) || (e == ELEM_R1W0_DN);
  endfunction

  // Background the element expects to read back (1 = all-ones).
  function automatic logic elem_exp_ones(input elem_e e);
    return (e == ELEM_R1W0_UP) || (e == ELEM_R1W0_DN);
  endfunction

  // Background the element writes (1 = all-ones).
  function automatic logic elem_wr_ones(input elem_e e);
    return (e == ELEM_R0W1_UP) || (e == ELEM_R0W1_DN);
  endfunction

  // Last counter value of an address slot.
  function automatic logic [3:0] elem_slot_last(input elem_e e);
    case (e)
      ELEM_W0: return SLOT_W - 4'd1;
      ELEM_R0: return SLOT_R - 4'd1;
      default: return SLOT_RW - 4'd1;
    endcase
  endfunction

endpackage

// File: rtl/marchc_engine_if.sv
// Controller/memory facing bundle of the March C engine. The engine takes the
// slave side; the controller plus SRAM wrapper take the master side.
interface marchc_engine_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
);
  logic                  start;
  logic                  en1;
  logic                  en2;
  logic                  en3;
  logic                  en4;
  logic                  en5;
  logic                  finish;
  logic [ADDR_WIDTH-1:0] address;
  logic [3:0]            counter;
  logic                  mem_we;
  logic                  mem_re;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  fail;
  logic [ADDR_WIDTH-1:0] fail_addr;
  logic [7:0]            err_cnt;
  logic [DATA_WIDTH-1:0] fail_data;
  logic                  done;

  modport master (
    output start, en1, en2, en3, en4, en5, finish, mem_rdata,
    input  address, counter, mem_we, mem_re, mem_wdata,
    input  fail, fail_addr, err_cnt, fail_data, done
  );

  modport slave (
    input  start, en1, en2, en3, en4, en5, finish, mem_rdata,
    output address, counter, mem_we, mem_re, mem_wdata,
    output fail, fail_addr, err_cnt, fail_data, done
  );
endinterface

// File: rtl/marchc_addr_gen.sv
// Loadable up/down address counter with terminal detect at 0 and all-ones.
module marchc_addr_gen #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic                  load_down_i,
  input  logic                  step_i,
  input  logic                  down_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  is_zero_o,
  output logic                  is_ones_o
);
  localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  // Next address: a load (element entry or abort) wins over a step.
  always_comb begin
    addr_d = addr_q;
    if (load_i) begin
      addr_d = load_down_i ? '1 : '0;
    end else if (step_i) begin
      addr_d = down_i ? (addr_q - ONE) : (addr_q + ONE);
    end
  end

  // Address register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) addr_q <= '0;
    else        addr_q <= addr_d;
  end

  assign addr_o    = addr_q;
  assign is_zero_o = (addr_q == '0);
  assign is_ones_o = &addr_q;
endmodule

// File: rtl/marchc_engine.sv
// March C engine: responds to the controller's one-hot element enables,
// sequences read/write/compare per address slot and logs mismatches.
// Optional macro MARCHC_FAIL_LOG_EN adds a first-mismatch syndrome register
// behind fail_data; without it fail_data is tied to 0.
module marchc_engine
  import marchc_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int RD_LAT     = 1
) (
  input logic            clk,
  input logic            rst_n,
  marchc_engine_if.slave bus
);
  localparam logic [3:0] PH_CMP = 4'(int'(PH_RD) + RD_LAT);

  state_e                state_q, state_d;
  elem_e                 elem_q, elem_d, sel_elem;
  logic [3:0]            counter_q, counter_d;
  logic [5:0]            en_q, en_vec, en_rise;
  logic                  sel_vld;
  logic [2:0]            sel_idx;
  logic                  ag_load, ag_load_down, ag_step;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  addr_zero, addr_ones, elem_down, at_term;
  logic                  run, slot_end, any_ctl, clr_log;
  logic                  cmp_en, mismatch;
  logic [DATA_WIDTH-1:0] exp_data;
  logic                  fail_q, fail_d;
  logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
  logic [7:0]            err_cnt_q, err_cnt_d;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : (v + 8'd1);
  endfunction

  assign en_vec    = {bus.en5, bus.en4, bus.en3, bus.en2, bus.en1, bus.start};
  assign en_rise   = en_vec & ~en_q;
  assign any_ctl   = (|en_vec) | bus.finish;
  assign run       = (state_q == ST_RUN);
  assign elem_down = elem_is_down(elem_q);
  assign at_term   = elem_down ? addr_zero : addr_ones;
  assign slot_end  = (counter_q == elem_slot_last(elem_q));

  // Lowest-index rising enable is the one taken.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (en_rise[i]) begin
        sel_vld = 1'b1;
        sel_idx = 3'(i);
      end
    end
  end
  assign sel_elem = elem_e'(sel_idx);

  // Enable history for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) en_q <= '0;
    else        en_q <= en_vec;
  end

  // FSM next state, slot counter and address generator control.
  always_comb begin
    state_d      = state_q;
    elem_d       = elem_q;
    counter_d    = counter_q;
    ag_load      = 1'b0;
    ag_load_down = 1'b0;
    ag_step      = 1'b0;
    clr_log      = 1'b0;
    if (bus.finish) begin
      state_d = ST_DONE;
    end else begin
      case (state_q)
        ST_IDLE, ST_HOLD, ST_DONE: begin
          if (sel_vld &&
              ((state_q == ST_IDLE) ||
               (state_q == ST_HOLD && sel_elem != elem_q) ||
               (state_q == ST_DONE && sel_elem == ELEM_W0))) begin
            state_d      = ST_RUN;
            elem_d       = sel_elem;
            counter_d    = 4'd0;
            ag_load      = 1'b1;
            ag_load_down = elem_is_down(sel_elem);
            clr_log      = (sel_elem == ELEM_W0);
          end
        end
        ST_RUN: begin
          if (!any_ctl) begin
            state_d   = ST_IDLE;
            counter_d = 4'd0;
            ag_load   = 1'b1;
          end else if (slot_end) begin
            if (at_term) begin
              state_d = ST_HOLD;
            end else begin
              counter_d = 4'd0;
              ag_step   = 1'b1;
            end
          end else begin
            counter_d = counter_q + 4'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM state, element and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      elem_q    <= ELEM_W0;
      counter_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      elem_q    <= elem_d;
      counter_q <= counter_d;
    end
  end

  marchc_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (ag_load),
    .load_down_i(ag_load_down),
    .step_i     (ag_step),
    .down_i     (elem_down),
    .addr_o     (addr),
    .is_zero_o  (addr_zero),
    .is_ones_o  (addr_ones)
  );

  assign exp_data = {DATA_WIDTH{elem_exp_ones(elem_q)}};
  assign cmp_en   = run && (elem_q != ELEM_W0) && (counter_q == PH_CMP);
  assign mismatch = cmp_en && (bus.mem_rdata != exp_data);

  // Mismatch log: sticky flag, first address, saturating count.
  always_comb begin
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    err_cnt_d   = err_cnt_q;
    if (clr_log) begin
      fail_d      = 1'b0;
      fail_addr_d = '0;
      err_cnt_d   = 8'd0;
    end else if (mismatch) begin
      fail_d    = 1'b1;
      err_cnt_d = sat_inc8(err_cnt_q);
      if (!fail_q) fail_addr_d = addr;
    end
  end

  // Mismatch log registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      err_cnt_q   <= 8'd0;
    end else begin
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

`ifdef MARCHC_FAIL_LOG_EN
  logic [DATA_WIDTH-1:0] fail_data_q, fail_data_d;

  // Syndrome of the first mismatch, held until the next start.
  always_comb begin
    fail_data_d = fail_data_q;
    if (clr_log)                 fail_data_d = '0;
    else if (mismatch && !fail_q) fail_data_d = bus.mem_rdata ^ exp_data;
  end

  // Syndrome register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fail_data_q <= '0;
    else        fail_data_q <= fail_data_d;
  end

  assign bus.fail_data = fail_data_q;
`else
  assign bus.fail_data = '0;
`endif

  assign bus.address   = addr;
  assign bus.counter   = counter_q;
  assign bus.mem_re    = run && (elem_q != ELEM_W0) && (counter_q == PH_RD);
  assign bus.mem_we    = run &&
                         (((elem_q == ELEM_W0) && (counter_q == PH_WR_W)) ||
                          ((elem_q inside {ELEM_R0W1_UP, ELEM_R1W0_UP,
                                           ELEM_R0W1_DN, ELEM_R1W0_DN}) &&
                           (counter_q == PH_WR_RW)));
  assign bus.mem_wdata = bus.mem_we ? {DATA_WIDTH{elem_wr_ones(elem_q)}} : '0;
  assign bus.fail      = fail_q;
  assign bus.fail_addr = fail_addr_q;
  assign bus.err_cnt   = err_cnt_q;
  assign bus.done      = (state_q == ST_DONE);
endmodule

// File: doc/marchc_engine.md
Name: marchc_engine

Overview:
- Responder side of the March C enable handshake.
- Consumes the one-hot element enables (start, en1..en5, finish) issued by the March C controller, and drives the address/counter pair back to it.
- Performs the memory read/write/compare operations of each March C element on the memory under test.
- Sits between the controller and the SRAM wrapper in the MBIST datapath.

Parameters:
ADDR_WIDTH, 16, memory address width; terminal addresses are 0 and all-ones.
DATA_WIDTH, 8, memory word width; background patterns are all-0 and all-1.
RD_LAT, 1, read latency in cycles (mem_re to valid mem_rdata); legal values 1..2.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  element 0 enable: up, w0.
en1  input  1  element 1 enable: up, r0 then w1.
en2  input  1  element 2 enable: up, r1 then w0.
en3  input  1  element 3 enable: down, r0 then w1.
en4  input  1  element 4 enable: down, r1 then w0.
en5  input  1  element 5 enable: up, r0.
finish  input  1  test-complete indication from the controller.
address  output  ADDR_WIDTH  current address; fed to the controller and the memory.
counter  output  4  cycle index within the current address slot.
mem_we  output  1  write strobe.
mem_re  output  1  read strobe.
mem_wdata  output  DATA_WIDTH  write data.
mem_rdata  input  DATA_WIDTH  read data, valid RD_LAT cycles after mem_re.
fail  output  1  sticky mismatch flag.
fail_addr  output  ADDR_WIDTH  address of the first mismatch.
err_cnt  output  8  mismatch count, saturates at 255.
fail_data  output  DATA_WIDTH  syndrome of the first mismatch (see Optional Feature).
done  output  1  test complete.

Behaviour:
- Reset: all outputs are 0; state is IDLE.
- States: IDLE, RUN, HOLD, DONE. RUN carries a 3-bit element register elem (0..5).

Slot lengths (counter counts 0..L-1 at each address):
- elem 0: L = 5.
- elem 1-4: L = 9.
- elem 5: L = 4.

Slot phases:
- mem_re = 1 at counter == 1 (elem 1-5).
- Compare at counter == 1+RD_LAT: mem_rdata against the expected pattern.
  - Expected is 0 for elem 1, 3, 5.
  - Expected is all-1 for elem 2, 4.
- mem_we = 1 at counter == 1 (elem 0) or counter == 5 (elem 1-4).
- mem_wdata is all-1 for elem 1, 3 and 0 for elem 0, 2, 4; it is 0 whenever mem_we = 0.

Address stepping:
- At counter == L-1, counter wraps to 0.
- Address then steps +1 (elem 0, 1, 2, 5) or -1 (elem 3, 4).

Terminal slot:
- The terminal address is all-ones for up elements and 0 for down elements.
- When counter == L-1 at the terminal address, go to HOLD.
- In HOLD, address and counter freeze at their terminal values (e.g. all-ones/8 after elem 1) and no memory strobes are issued.

Element entry:
- IDLE or HOLD, on a rising edge of an enable whose index differs from elem: go to RUN.
- Load elem and counter = 0.
- Load address = 0 for up elements, all-ones for down elements.
- On a rising edge of start, also clear fail, fail_addr, err_cnt and fail_data.

Other transitions:
- More than one enable high: the lowest index wins.
- RUN and all enables and finish low (controller re-initialised): abort to IDLE. Address and counter clear to 0; no further strobes.
- finish high in any state: go to DONE, done = 1. done stays high until the next start rising edge.

Compare and error rules:
- A compare mismatch sets fail; err_cnt increments.
- fail_addr captures the address of the first mismatch only.
- No compare is performed in HOLD, IDLE or DONE.
- An address step and an element entry never coincide. The controller cannot issue a new enable before HOLD; an enable rising during RUN with a different index is ignored.

Optional Feature:
- Macro: MARCHC_FAIL_LOG_EN.
- Defined: fail_data captures mem_rdata XOR expected at the first mismatch. It holds that value until start clears it.
- Undefined: fail_data is tied to 0 and no capture register exists.
- Either way the port list is unchanged.

Decomposition:
- Package marchc_pkg holds:
  - element encodings ELEM_W0 .. ELEM_R0;
  - slot lengths SLOT_W = 5, SLOT_RW = 9, SLOT_R = 4;
  - phase constants PH_RD = 1, PH_WR_RW = 5, PH_WR_W = 1;
  - per-element direction, expected-data and write-data lookup functions.
- Sub-module marchc_addr_gen: loadable up/down ADDR_WIDTH counter with a step enable and terminal detect for both directions.

Test Plan:
1. Full pass, fault-free model, ADDR_WIDTH=4, RD_LAT=1:
   - Drive start, en1..en5, finish in sequence, each after HOLD.
   - Expect 16 writes of 0 in elem 0, then mem_we count totals 80.
   - Expect fail = 0, err_cnt = 0, done = 1.
2. Stuck-at-1 at address 0x5, full pass:
   - Expect fail = 1, fail_addr = 0x5, err_cnt = 3 (elem 1, 3, 5 reads).
   - With MARCHC_FAIL_LOG_EN, expect fail_data = 0x01 for a bit-0 fault.
3. Down element entry:
   - en3 rising from HOLD at all-ones/8 gives address = all-ones and counter = 0 on the next cycle.
   - The terminal slot at address 0 ends in HOLD with counter = 8.
4. Abort: in RUN at address 0x7, drop all enables -> next cycle IDLE, address = 0, no mem_we/mem_re afterwards.
5. Async reset: assert rst_n = 0 mid-elem 2 -> all outputs 0 immediately; after release the engine stays in IDLE until start.
6. RD_LAT = 2, elem 5 at address 0x3 with rdata = 0xFF -> compare at counter 3 raises fail; err_cnt saturates at 255 after 300 forced mismatches.
